// File: rtl/npu_requant_writeback.sv
// rtl/npu_requant_writeback.sv - INT32 accumulator beat -> bias add, requantize, clamp, packed INT8 writeback
// Three-stage stall-as-one pipeline under a single-job IDLE/RUN/DRAIN/DONE controller.
module npu_requant_writeback #(
  parameter int LANES  = 16,
  parameter int ACC_W  = 32,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7:0]              cfg_scale,
  input  logic [7:0]              cfg_shift,
  input  logic                    cfg_bias_en,
  input  logic [CNT_W-1:0]        cfg_num_beats,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*ACC_W-1:0]  in_acc,
  input  logic [LANES*ACC_W-1:0]  in_bias,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        sat_count
);
  localparam int PROD_W = ACC_W + 9;
  localparam int RND_W  = PROD_W + 1;
  localparam int NSAT_W = $clog2(LANES + 1);
  localparam logic signed [RND_W-1:0] Q_MAX = RND_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [RND_W-1:0] Q_MIN = RND_W'(-(2 ** (DATA_W - 1)));

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              scale_q, scale_d;
  logic [4:0]              shift_q, shift_d;
  logic                    bias_en_q, bias_en_d;
  logic [CNT_W-1:0]        num_beats_q, num_beats_d;
  logic [CNT_W-1:0]        in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]        sat_count_q, sat_count_d;
  logic                    s1_valid_q, s1_valid_d;
  logic                    s2_valid_q, s2_valid_d;
  logic                    s3_valid_q, s3_valid_d;
  logic [LANES*ACC_W-1:0]  s1_b_q, s1_b_d;
  logic [LANES-1:0]        s1_sat_q, s1_sat_d;
  logic [LANES-1:0]        s2_sat_q, s2_sat_d;
  logic [LANES*PROD_W-1:0] s2_p_q, s2_p_d;
  logic [LANES*DATA_W-1:0] s3_data_q, s3_data_d;
  logic [NSAT_W-1:0]       s3_nsat_q, s3_nsat_d;

  logic                    stall, xfer, out_hs, last_beat, clip;
  logic [ACC_W:0]          add_sum;
  logic [PROD_W-1:0]       mul_a, mul_b;
  logic signed [RND_W-1:0] rnd_add, rnd_val, q_val;
  logic [CNT_W:0]          sat_sum;

  assign stall     = s3_valid_q & ~out_ready;
  assign in_ready  = (state_q == S_RUN) & (in_cnt_q < num_beats_q) & ~stall;
  assign xfer      = in_valid & in_ready;
  assign out_hs    = s3_valid_q & out_ready;
  assign last_beat = (out_cnt_q == num_beats_q - CNT_W'(1));

  assign out_valid = s3_valid_q;
  assign out_data  = s3_data_q;
  assign out_last  = s3_valid_q & last_beat;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign sat_count = sat_count_q;

  always_comb begin
    s1_valid_d = stall ? s1_valid_q : xfer;
    s2_valid_d = stall ? s2_valid_q : s1_valid_q;
    s3_valid_d = stall ? s3_valid_q : s2_valid_q;
  end

  // S1: saturating bias add; overflow shows as the two top bits of the 33-bit sum disagreeing
  always_comb begin
    s1_b_d   = s1_b_q;
    s1_sat_d = s1_sat_q;
    add_sum  = '0;
    if (!stall) begin
      for (int i = 0; i < LANES; i++) begin
        add_sum = {in_acc[i*ACC_W+ACC_W-1], in_acc[i*ACC_W +: ACC_W]}
                + {in_bias[i*ACC_W+ACC_W-1], in_bias[i*ACC_W +: ACC_W]};
        s1_sat_d[i] = 1'b0;
        if (!bias_en_q) begin
          s1_b_d[i*ACC_W +: ACC_W] = in_acc[i*ACC_W +: ACC_W];
        end else if (add_sum[ACC_W] != add_sum[ACC_W-1]) begin
          s1_sat_d[i] = 1'b1;
          s1_b_d[i*ACC_W +: ACC_W] = add_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                    : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
          s1_b_d[i*ACC_W +: ACC_W] = add_sum[ACC_W-1:0];
        end
      end
    end
  end

  // S2: the true product always fits PROD_W, so a modulo multiply of sign-extended operands is exact
  always_comb begin
    s2_p_d   = s2_p_q;
    s2_sat_d = s2_sat_q;
    mul_a    = '0;
    mul_b    = '0;
    if (!stall) begin
      s2_sat_d = s1_sat_q;
      mul_b    = {{(PROD_W-8){1'b0}}, scale_q};
      for (int i = 0; i < LANES; i++) begin
        mul_a = {{(PROD_W-ACC_W){s1_b_q[i*ACC_W+ACC_W-1]}}, s1_b_q[i*ACC_W +: ACC_W]};
        s2_p_d[i*PROD_W +: PROD_W] = mul_a * mul_b;
      end
    end
  end

  always_comb begin
    s3_data_d = s3_data_q;
    s3_nsat_d = s3_nsat_q;
    rnd_add   = '0;
    rnd_val   = '0;
    q_val     = '0;
    clip      = 1'b0;
    if (!stall) begin
      s3_nsat_d = '0;
      rnd_add   = (shift_q == 5'd0) ? '0 : (RND_W'(1) << (shift_q - 5'd1));
      for (int i = 0; i < LANES; i++) begin
        rnd_val = $signed({s2_p_q[i*PROD_W+PROD_W-1], s2_p_q[i*PROD_W +: PROD_W]}) + rnd_add;
        q_val   = rnd_val >>> shift_q;
        clip    = 1'b1;
        if (q_val > Q_MAX) begin
          s3_data_d[i*DATA_W +: DATA_W] = DATA_W'(Q_MAX);
        end else if (q_val < Q_MIN) begin
          s3_data_d[i*DATA_W +: DATA_W] = DATA_W'(Q_MIN);
        end else begin
          s3_data_d[i*DATA_W +: DATA_W] = q_val[DATA_W-1:0];
          clip = 1'b0;
        end
        s3_nsat_d = s3_nsat_d + NSAT_W'(clip | s2_sat_q[i]);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    scale_d     = scale_q;
    shift_d     = shift_q;
    bias_en_d   = bias_en_q;
    num_beats_d = num_beats_q;
    in_cnt_d    = in_cnt_q + CNT_W'(xfer);
    out_cnt_d   = out_cnt_q + CNT_W'(out_hs);
    sat_sum     = {1'b0, sat_count_q} + (CNT_W+1)'(s3_nsat_q);
    sat_count_d = sat_count_q;
    if (out_hs) sat_count_d = sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
    case (state_q)
      S_IDLE: begin
        if (start) begin
          scale_d     = cfg_scale;
          shift_d     = (cfg_shift > 8'd31) ? 5'd31 : cfg_shift[4:0];
          bias_en_d   = cfg_bias_en;
          num_beats_d = cfg_num_beats;
          in_cnt_d    = '0;
          out_cnt_d   = '0;
          sat_count_d = '0;
          state_d     = (cfg_num_beats != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN:   if (in_cnt_q == num_beats_q) state_d = S_DRAIN;
      S_DRAIN: if (out_hs && last_beat) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      scale_q     <= '0;
      shift_q     <= '0;
      bias_en_q   <= 1'b0;
      num_beats_q <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      sat_count_q <= '0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      s1_b_q      <= '0;
      s1_sat_q    <= '0;
      s2_sat_q    <= '0;
      s2_p_q      <= '0;
      s3_data_q   <= '0;
      s3_nsat_q   <= '0;
    end else begin
      state_q     <= state_d;
      scale_q     <= scale_d;
      shift_q     <= shift_d;
      bias_en_q   <= bias_en_d;
      num_beats_q <= num_beats_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      sat_count_q <= sat_count_d;
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s3_valid_q  <= s3_valid_d;
      s1_b_q      <= s1_b_d;
      s1_sat_q    <= s1_sat_d;
      s2_sat_q    <= s2_sat_d;
      s2_p_q      <= s2_p_d;
      s3_data_q   <= s3_data_d;
      s3_nsat_q   <= s3_nsat_d;
    end
  end
endmodule
